// File: rtl/vend_session_ctrl_if.sv
// rtl/vend_session_ctrl_if.sv - coin, price, dispense and change signals of the vending session controller
interface vend_session_ctrl_if;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       cancel;
  logic       price_we;
  logic [3:0] price_in;
  logic       disp_req;
  logic       disp_ack;
  logic       chg_req;
  logic       chg_ack;
  logic [4:0] credit;
  logic       busy;
  logic       coin_reject;

  modport master (
    output coin_valid, coin_val, cancel, price_we, price_in, disp_ack, chg_ack,
    input  disp_req, chg_req, credit, busy, coin_reject
  );

  modport slave (
    input  coin_valid, coin_val, cancel, price_we, price_in, disp_ack, chg_ack,
    output disp_req, chg_req, credit, busy, coin_reject
  );
endinterface

// File: rtl/vend_session_ctrl.sv
// rtl/vend_session_ctrl.sv - vending session FSM: coin credit, vend, change return, timeout refund
module vend_session_ctrl #(
  parameter int unsigned PRICE_DEFAULT = 3,
  parameter int unsigned TIMEOUT       = 200
) (
  input  logic           clk,
  input  logic           rst,
  vend_session_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  state_t      state, state_nxt;
  logic [4:0]  credit_q, credit_nxt;
  logic [3:0]  price_q, price_nxt;
  logic [15:0] idle_cnt, idle_cnt_nxt;
  logic        disp_req_q, chg_req_q, busy_q, coin_reject_q;
  logic [4:0]  coin_units;
  logic        vend_cond, coin_ok, timeout_hit;

  always_comb begin
    case (bus.coin_val)
      2'b01:   coin_units = 5'd1;
      2'b10:   coin_units = 5'd2;
      2'b11:   coin_units = 5'd5;
      default: coin_units = 5'd0;
    endcase
  end

  // A pending vend takes priority over a coin, cancel or timeout in the same cycle
  assign vend_cond   = (state == CREDIT) && (credit_q >= {1'b0, price_q});
  assign coin_ok     = bus.coin_valid && (bus.coin_val != 2'b00) &&
                       ((state == IDLE) || (state == CREDIT)) &&
                       !bus.cancel && !vend_cond;
  assign timeout_hit = ({1'b0, idle_cnt} + 17'd1) >= TIMEOUT_W;

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit_q;
    price_nxt    = price_q;
    idle_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (bus.price_we && (bus.price_in != 4'd0)) price_nxt = bus.price_in;
        if (coin_ok) begin
          state_nxt  = CREDIT;
          credit_nxt = coin_units;
        end
      end
      CREDIT: begin
        if (vend_cond) begin
          state_nxt  = VEND;
          credit_nxt = credit_q - {1'b0, price_q};
        end else if (bus.cancel) begin
          state_nxt = CHANGE;
        end else if (coin_ok) begin
          credit_nxt = credit_q + coin_units;
        end else if (timeout_hit) begin
          state_nxt = CHANGE;
        end else begin
          idle_cnt_nxt = idle_cnt + 16'd1;
        end
      end
      VEND: begin
        if (bus.disp_ack) state_nxt = (credit_q != 5'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (bus.chg_ack && (credit_q != 5'd0)) begin
          credit_nxt = credit_q - 5'd1;
          if (credit_q == 5'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      credit_q      <= 5'd0;
      price_q       <= 4'(PRICE_DEFAULT);
      idle_cnt      <= 16'd0;
      disp_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit_q      <= credit_nxt;
      price_q       <= price_nxt;
      idle_cnt      <= idle_cnt_nxt;
      disp_req_q    <= (state_nxt == VEND);
      chg_req_q     <= (state_nxt == CHANGE);
      busy_q        <= (state_nxt == VEND) || (state_nxt == CHANGE);
      coin_reject_q <= bus.coin_valid && !coin_ok;
    end
  end

  assign bus.credit      = credit_q;
  assign bus.disp_req    = disp_req_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// tb/tb_vend_session_ctrl.sv - vector table and scoreboard bench for vend_session_ctrl
module tb_vend_session_ctrl;

  typedef struct {
    logic       r;
    logic       cv;
    logic [1:0] cval;
    logic       can;
    logic       pwe;
    logic [3:0] pin;
    logic       dack;
    logic       cack;
    logic [8:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } sb_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  vend_session_ctrl_if bus ();

  vend_session_ctrl #(.PRICE_DEFAULT(3), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs: credit, disp_req, chg_req, busy (= disp_req|chg_req), coin_reject
  function automatic vec_t mk(input string name, input int r, input int cv, input int cval,
                              input int can, input int pwe, input int pin, input int dack,
                              input int cack, input int cr, input int dq, input int cq,
                              input int rj);
    vec_t v;
    v.name = name;
    v.r    = r[0];
    v.cv   = cv[0];
    v.cval = 2'(cval);
    v.can  = can[0];
    v.pwe  = pwe[0];
    v.pin  = 4'(pin);
    v.dack = dack[0];
    v.cack = cack[0];
    v.exp  = {5'(cr), dq[0], cq[0], dq[0] | cq[0], rj[0]};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t        e;
    sb_t        got_e;
    logic [8:0] got;
    rst            = v.r;
    bus.coin_valid = v.cv;
    bus.coin_val   = v.cval;
    bus.cancel     = v.can;
    bus.price_we   = v.pwe;
    bus.price_in   = v.pin;
    bus.disp_ack   = v.dack;
    bus.chg_ack    = v.cack;
    e.exp  = v.exp;
    e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got   = {bus.credit, bus.disp_req, bus.chg_req, bus.busy, bus.coin_reject};
    got_e = sb.pop_front();
    checks++;
    if (got !== got_e.exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d disp=%b chg=%b busy=%b rej=%b, expected credit=%0d disp=%b chg=%b busy=%b rej=%b",
               got_e.name, got[8:4], got[3], got[2], got[1], got[0],
               got_e.exp[8:4], got_e.exp[3], got_e.exp[2], got_e.exp[1], got_e.exp[0]);
    end
  endtask

  task automatic idle(input string name, input int cr, input int dq, input int cq);
    apply(mk(name, 1, 0, 0, 0, 0, 0, 0, 0, cr, dq, cq, 0));
  endtask

  task automatic coin(input string name, input int val, input int cr, input int dq, input int cq, input int rj);
    apply(mk(name, 1, 1, val, 0, 0, 0, 0, 0, cr, dq, cq, rj));
  endtask

  initial begin
    rst = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_val   = 2'b00;
    bus.cancel     = 1'b0;
    bus.price_we   = 1'b0;
    bus.price_in   = 4'd0;
    bus.disp_ack   = 1'b0;
    bus.chg_ack    = 1'b0;

    //                  name             r cv cv can pwe pin dack cack | cr dq cq rj
    vecs.push_back(mk("rst_coin_a",      0, 1, 1, 0, 0, 0, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk("rst_coin_b",      0, 1, 3, 0, 0, 0, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk("exact_c1",        1, 1, 1, 0, 0, 0, 0, 0,        1, 0, 0, 0));
    vecs.push_back(mk("exact_c2",        1, 1, 1, 0, 0, 0, 0, 0,        2, 0, 0, 0));
    vecs.push_back(mk("exact_c3",        1, 1, 1, 0, 0, 0, 0, 0,        3, 0, 0, 0));
    vecs.push_back(mk("exact_vend",      1, 0, 0, 0, 0, 0, 0, 0,        0, 1, 0, 0));
    vecs.push_back(mk("exact_hold",      1, 0, 0, 0, 0, 0, 0, 0,        0, 1, 0, 0));
    vecs.push_back(mk("exact_ack",       1, 0, 0, 0, 0, 0, 1, 0,        0, 0, 0, 0));
    vecs.push_back(mk("over_c5",         1, 1, 3, 0, 0, 0, 0, 0,        5, 0, 0, 0));
    vecs.push_back(mk("over_vend",       1, 0, 0, 0, 0, 0, 0, 0,        2, 1, 0, 0));
    vecs.push_back(mk("over_dack",       1, 0, 0, 0, 0, 0, 1, 0,        2, 0, 1, 0));
    vecs.push_back(mk("over_cack1",      1, 0, 0, 0, 0, 0, 0, 1,        1, 0, 1, 0));
    vecs.push_back(mk("over_wait",       1, 0, 0, 0, 0, 0, 0, 0,        1, 0, 1, 0));
    vecs.push_back(mk("over_cack2",      1, 0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0));
    vecs.push_back(mk("cancel_c2",       1, 1, 2, 0, 0, 0, 0, 0,        2, 0, 0, 0));
    vecs.push_back(mk("cancel_coin",     1, 1, 1, 1, 0, 0, 0, 0,        2, 0, 1, 1));
    vecs.push_back(mk("change_coin",     1, 1, 3, 0, 0, 0, 0, 0,        2, 0, 1, 1));
    vecs.push_back(mk("cancel_cack1",    1, 0, 0, 0, 0, 0, 0, 1,        1, 0, 1, 0));
    vecs.push_back(mk("cancel_cack2",    1, 0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0));
    vecs.push_back(mk("coin_zero",       1, 1, 0, 0, 0, 0, 0, 0,        0, 0, 0, 1));
    vecs.push_back(mk("idle_ignore",     1, 0, 0, 1, 0, 0, 1, 1,        0, 0, 0, 0));
    vecs.push_back(mk("price_zero",      1, 0, 0, 0, 1, 0, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk("p3_c2",           1, 1, 2, 0, 0, 0, 0, 0,        2, 0, 0, 0));
    vecs.push_back(mk("p3_c3",           1, 1, 1, 0, 0, 0, 0, 0,        3, 0, 0, 0));
    vecs.push_back(mk("pwe_credit",      1, 0, 0, 0, 1, 5, 0, 0,        0, 1, 0, 0));
    vecs.push_back(mk("pwe_vend",        1, 0, 0, 0, 1, 5, 0, 0,        0, 1, 0, 0));
    vecs.push_back(mk("pwe_vend_ack",    1, 0, 0, 0, 0, 0, 1, 0,        0, 0, 0, 0));
    vecs.push_back(mk("p3_keep_c5",      1, 1, 3, 0, 0, 0, 0, 0,        5, 0, 0, 0));
    vecs.push_back(mk("p3_keep_vend",    1, 0, 0, 0, 0, 0, 0, 0,        2, 1, 0, 0));
    vecs.push_back(mk("rst_mid_vend",    0, 1, 1, 1, 0, 0, 1, 1,        0, 0, 0, 0));
    vecs.push_back(mk("post_rst_c5",     1, 1, 3, 0, 0, 0, 0, 0,        5, 0, 0, 0));
    vecs.push_back(mk("post_rst_vend",   1, 0, 0, 0, 0, 0, 0, 0,        2, 1, 0, 0));
    vecs.push_back(mk("post_rst_dack",   1, 0, 0, 0, 0, 0, 1, 0,        2, 0, 1, 0));
    vecs.push_back(mk("rst_mid_change",  0, 0, 0, 0, 0, 0, 0, 1,        0, 0, 0, 0));
    vecs.push_back(mk("price4_we",       1, 0, 0, 0, 1, 4, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk("p4_c2",           1, 1, 2, 0, 0, 0, 0, 0,        2, 0, 0, 0));
    vecs.push_back(mk("p4_c3",           1, 1, 1, 0, 0, 0, 0, 0,        3, 0, 0, 0));
    vecs.push_back(mk("p4_short",        1, 0, 0, 0, 0, 0, 0, 0,        3, 0, 0, 0));
    vecs.push_back(mk("p4_c4",           1, 1, 1, 0, 0, 0, 0, 0,        4, 0, 0, 0));
    vecs.push_back(mk("p4_vend",         1, 0, 0, 0, 0, 0, 0, 0,        0, 1, 0, 0));
    vecs.push_back(mk("vend_coin_rej",   1, 1, 1, 0, 0, 0, 0, 0,        0, 1, 0, 1));
    vecs.push_back(mk("p4_dack",         1, 0, 0, 0, 0, 0, 1, 0,        0, 0, 0, 0));
    vecs.push_back(mk("price2_we",       1, 0, 0, 0, 1, 2, 0, 0,        0, 0, 0, 0));
    vecs.push_back(mk("p2_c2",           1, 1, 2, 0, 0, 0, 0, 0,        2, 0, 0, 0));
    vecs.push_back(mk("vend_beats_can",  1, 1, 1, 1, 0, 0, 0, 0,        0, 1, 0, 1));
    vecs.push_back(mk("p2_dack",         1, 0, 0, 0, 0, 0, 1, 0,        0, 0, 0, 0));
    vecs.push_back(mk("price15_we",      1, 0, 0, 0, 1, 15, 0, 0,       0, 0, 0, 0));
    vecs.push_back(mk("max_c5",          1, 1, 3, 0, 0, 0, 0, 0,        5, 0, 0, 0));
    vecs.push_back(mk("max_c10",         1, 1, 3, 0, 0, 0, 0, 0,       10, 0, 0, 0));
    vecs.push_back(mk("max_c12",         1, 1, 2, 0, 0, 0, 0, 0,       12, 0, 0, 0));
    vecs.push_back(mk("max_c14",         1, 1, 2, 0, 0, 0, 0, 0,       14, 0, 0, 0));
    vecs.push_back(mk("max_c19",         1, 1, 3, 0, 0, 0, 0, 0,       19, 0, 0, 0));
    vecs.push_back(mk("max_vend",        1, 0, 0, 0, 0, 0, 0, 0,        4, 1, 0, 0));
    vecs.push_back(mk("max_dack",        1, 0, 0, 0, 0, 0, 1, 0,        4, 0, 1, 0));
    vecs.push_back(mk("max_rst",         0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    coin("to_c1", 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) idle("to_wait", 1, 0, 0);
    idle("to_expire", 1, 0, 1);
    apply(mk("to_cack", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    coin("to2_c1", 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle("to2_wait_a", 1, 0, 0);
    coin("to2_c2", 1, 2, 0, 0, 0);
    for (int i = 0; i < 7; i++) idle("to2_wait_b", 2, 0, 0);
    idle("to2_expire", 2, 0, 1);
    apply(mk("to2_cack1", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    apply(mk("to2_cack2", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
